// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter in front of the single-port data memory.
// Each requester holds req with stable fields until its one-cycle ack. A
// transaction takes three cycles: IDLE (grant), ACCESS (memory cycle) and RESP (ack).
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req/we/addr/wdata{0,1}        requester transaction inputs
//   ack{0,1}, rdata{0,1}          completion pulse and held read data per requester
//   mem_addr, mem_din, mem_we     memory address, write data and write strobe
//   mem_dout                      memory read data (combinational read)
//   busy                          high while in ACCESS or RESP
//   gnt                           index of the port currently or last granted
module dm_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              gnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                sel_c;
  logic                we_q;
  logic                we_d;
  logic                gnt_d;
  logic                busy_d;
  logic                ack0_d;
  logic                ack1_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_din_d;
  logic [DATA_W-1:0]   rdata0_d;
  logic [DATA_W-1:0]   rdata1_d;

  // Winner: a lone requester, or on a tie the port that was not granted last.
  assign sel_c = (req0 && req1) ? ~gnt : req1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests only matter in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 || req1) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the latched request.
  always_comb begin
    gnt_d      = gnt;
    we_d       = we_q;
    mem_addr_d = mem_addr;
    mem_din_d  = mem_din;
    rdata0_d   = rdata0;
    rdata1_d   = rdata1;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    busy_d     = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d      = sel_c;
          we_d       = sel_c ? we1    : we0;
          mem_addr_d = sel_c ? addr1  : addr0;
          mem_din_d  = sel_c ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        // Memory read is combinational, so dout is valid at the closing edge.
        if (gnt) begin
          ack1_d = 1'b1;
          if (!we_q) rdata1_d = mem_dout;
        end else begin
          ack0_d = 1'b1;
          if (!we_q) rdata0_d = mem_dout;
        end
      end
      default: ;
    endcase
  end

  // Strobe decoded from state so an async reset during ACCESS kills the write.
  assign mem_we = (state_q == ACCESS) && we_q;

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= 1'b1;
      we_q     <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      gnt      <= gnt_d;
      we_q     <= we_d;
      mem_addr <= mem_addr_d;
      mem_din  <= mem_din_d;
      rdata0   <= rdata0_d;
      rdata1   <= rdata1_d;
      ack0     <= ack0_d;
      ack1     <= ack1_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 1024x32 memory model.
module tb_dm_arbiter;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic [DATA_W-1:0] mem_dout;
  logic              busy, gnt;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int tests = 0;
  int fails = 0;

  dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .busy(busy), .gnt(gnt)
  );

  always #5 clk = ~clk;

  // Memory: combinational read, write on rising edge.
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    #12;
    check("rst_ack0", 64'(ack0), 64'd0);
    check("rst_ack1", 64'(ack1), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_gnt", 64'(gnt), 64'd1);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_rdata0", 64'(rdata0), 64'd0);
    rst_n = 1'b1;
    tick();

    // Port 0 write 0x005 <- DEADBEEF
    req0 = 1; we0 = 1; addr0 = 10'h005; wdata0 = 32'hDEADBEEF;
    tick();
    check("wr_access_we", 64'(mem_we), 64'd1);
    check("wr_access_addr", 64'(mem_addr), 64'h005);
    check("wr_access_din", 64'(mem_din), 64'hDEADBEEF);
    check("wr_access_gnt", 64'(gnt), 64'd0);
    check("wr_access_busy", 64'(busy), 64'd1);
    check("wr_access_ack0", 64'(ack0), 64'd0);
    tick();
    check("wr_resp_ack0", 64'(ack0), 64'd1);
    check("wr_resp_we", 64'(mem_we), 64'd0);
    check("wr_mem5", 64'(mem[5]), 64'hDEADBEEF);
    req0 = 0;
    tick();
    check("wr_idle_ack0", 64'(ack0), 64'd0);
    check("wr_idle_busy", 64'(busy), 64'd0);
    check("wr_idle_we", 64'(mem_we), 64'd0);

    // Port 0 read back 0x005
    req0 = 1; we0 = 0;
    tick();
    check("rd_access_we", 64'(mem_we), 64'd0);
    tick();
    check("rd_resp_ack0", 64'(ack0), 64'd1);
    check("rd_resp_ack1", 64'(ack1), 64'd0);
    check("rd_rdata0", 64'(rdata0), 64'hDEADBEEF);
    req0 = 0;
    tick();

    // Tie after reset: port 0 first, then port 1
    rst_n = 1'b0; #2; rst_n = 1'b1;
    req0 = 1; we0 = 1; addr0 = 10'h001; wdata0 = 32'h11111111;
    req1 = 1; we1 = 1; addr1 = 10'h002; wdata1 = 32'h22222222;
    tick();
    check("tie_gnt_first", 64'(gnt), 64'd0);
    check("tie_addr_first", 64'(mem_addr), 64'h001);
    tick();
    check("tie_ack0", 64'(ack0), 64'd1);
    req0 = 0;
    tick();
    tick();
    check("tie_gnt_second", 64'(gnt), 64'd1);
    check("tie_addr_second", 64'(mem_addr), 64'h002);
    check("tie_we_second", 64'(mem_we), 64'd1);
    tick();
    check("tie_ack1", 64'(ack1), 64'd1);
    check("tie_ack0_low", 64'(ack0), 64'd0);
    req1 = 0;
    tick();
    check("tie_mem1", 64'(mem[1]), 64'h11111111);
    check("tie_mem2", 64'(mem[2]), 64'h22222222);

    // Continuous contention: 4 reads each, grants alternate starting at 0
    begin
      int left0 = 4;
      int left1 = 4;
      req0 = 1; we0 = 0; addr0 = 10'h001;
      req1 = 1; we1 = 0; addr1 = 10'h002;
      for (int i = 0; i < 8; i++) begin
        logic p;
        p = 1'(i % 2);
        tick();
        check($sformatf("cont_gnt_%0d", i), 64'(gnt), 64'(p));
        tick();
        check($sformatf("cont_ack0_%0d", i), 64'(ack0), 64'(!p));
        check($sformatf("cont_ack1_%0d", i), 64'(ack1), 64'(p));
        if (p) begin
          check($sformatf("cont_rdata1_%0d", i), 64'(rdata1), 64'h22222222);
          left1--;
          if (left1 == 0) req1 = 0;
        end else begin
          check($sformatf("cont_rdata0_%0d", i), 64'(rdata0), 64'h11111111);
          left0--;
          if (left0 == 0) req0 = 0;
        end
        tick();
      end
    end

    // Late request: req1 raised during port 0 ACCESS is not sampled until IDLE
    req0 = 1; we0 = 0; addr0 = 10'h005;
    tick();
    check("late_gnt0", 64'(gnt), 64'd0);
    req1 = 1; we1 = 0; addr1 = 10'h001;
    tick();
    check("late_ack0", 64'(ack0), 64'd1);
    check("late_ack1_low", 64'(ack1), 64'd0);
    check("late_rdata0", 64'(rdata0), 64'hDEADBEEF);
    req0 = 0;
    tick();
    check("late_idle_busy", 64'(busy), 64'd0);
    check("late_idle_gnt", 64'(gnt), 64'd0);
    tick();
    check("late_gnt1", 64'(gnt), 64'd1);
    check("late_addr1", 64'(mem_addr), 64'h001);
    tick();
    check("late_ack1", 64'(ack1), 64'd1);
    check("late_rdata1", 64'(rdata1), 64'h11111111);
    req1 = 0;
    tick();

    // Retention: port 1 writes then reads 0x010, then idles
    req1 = 1; we1 = 1; addr1 = 10'h010; wdata1 = 32'h12345678;
    tick(); tick();
    req1 = 0;
    tick();
    req1 = 1; we1 = 0;
    tick(); tick();
    check("ret_ack1", 64'(ack1), 64'd1);
    check("ret_rdata1", 64'(rdata1), 64'h12345678);
    req1 = 0;
    for (int i = 0; i < 10; i++) tick();
    check("ret_rdata1_hold", 64'(rdata1), 64'h12345678);
    check("ret_rdata0_hold", 64'(rdata0), 64'hDEADBEEF);
    check("ret_ack1_low", 64'(ack1), 64'd0);
    check("ret_mem_addr_hold", 64'(mem_addr), 64'h010);

    // Reset asserted during ACCESS of a write
    req0 = 1; we0 = 1; addr0 = 10'h3FF; wdata0 = 32'hCAFEF00D;
    tick();
    check("rstw_access_we", 64'(mem_we), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw_we_drop", 64'(mem_we), 64'd0);
    check("rstw_busy", 64'(busy), 64'd0);
    check("rstw_gnt", 64'(gnt), 64'd1);
    check("rstw_mem_addr", 64'(mem_addr), 64'd0);
    check("rstw_mem_din", 64'(mem_din), 64'd0);
    check("rstw_rdata1", 64'(rdata1), 64'd0);
    req0 = 0;
    tick();
    check("rstw_mem3ff", 64'(mem[10'h3FF]), 64'd0);
    check("rstw_ack0", 64'(ack0), 64'd0);
    rst_n = 1'b1;
    tick(); tick();
    check("rstw_post_ack0", 64'(ack0), 64'd0);
    check("rstw_post_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
